// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: walks an active-low column drive, debounces one
// press, strobes the key code into the data latch and handshakes with the shifter.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_drive,
    output logic [1:0] col_sel,
    output logic [3:0] rows_out,
    output logic       latch_en,
    output logic       data_ready,
    input  logic       data_ack
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CNT);
    localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);

    localparam logic [2:0] S_SCAN     = 3'd0;
    localparam logic [2:0] S_DEBOUNCE = 3'd1;
    localparam logic [2:0] S_LATCH    = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_RELEASE  = 3'd4;

    logic [2:0]       r_state;
    logic [DIV_W-1:0] r_dwell;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [1:0]       r_scan_col;
    logic [3:0]       r_col_drive;
    logic [3:0]       r_cand;
    logic [DEB_W-1:0] r_deb;
    logic [1:0]       r_col_sel;
    logic [3:0]       r_rows_out;
    logic             r_latch_en;
    logic             r_data_ready;

    logic             w_tick;
    logic [3:0]       w_rows_s;
    logic [DEB_W-1:0] w_deb_inc;
    logic [2:0]       w_state_nxt;
    logic [1:0]       w_col_nxt;
    logic [3:0]       w_col_drive_nxt;
    logic [3:0]       w_cand_nxt;
    logic [DEB_W-1:0] w_deb_nxt;
    logic [1:0]       w_col_sel_nxt;
    logic [3:0]       w_rows_out_nxt;
    logic             w_latch_en_nxt;
    logic             w_data_ready_nxt;

    assign w_tick    = (r_dwell == DIV_MAX);
    assign w_rows_s  = ~r_sync2;
    assign w_deb_inc = r_deb + DEB_ONE;

    assign col_drive  = r_col_drive;
    assign col_sel    = r_col_sel;
    assign rows_out   = r_rows_out;
    assign latch_en   = r_latch_en;
    assign data_ready = r_data_ready;

    // Next-state and output decode; the key code is registered together with the strobe
    always_comb begin
        w_state_nxt      = r_state;
        w_col_nxt        = r_scan_col;
        w_cand_nxt       = r_cand;
        w_deb_nxt        = r_deb;
        w_col_sel_nxt    = r_col_sel;
        w_rows_out_nxt   = r_rows_out;
        w_latch_en_nxt   = 1'b0;
        w_data_ready_nxt = r_data_ready;

        case (r_state)
            S_SCAN: begin
                if (w_tick) begin
                    if (w_rows_s == 4'd0) begin
                        w_col_nxt = r_scan_col + 2'd1;
                    end else begin
                        w_cand_nxt = w_rows_s;
                        if (DEB_MAX == DEB_ONE) begin
                            w_state_nxt    = S_LATCH;
                            w_deb_nxt      = '0;
                            w_latch_en_nxt = 1'b1;
                            w_col_sel_nxt  = r_scan_col;
                            w_rows_out_nxt = w_rows_s;
                        end else begin
                            w_state_nxt = S_DEBOUNCE;
                            w_deb_nxt   = DEB_ONE;
                        end
                    end
                end
            end
            S_DEBOUNCE: begin
                if (w_tick) begin
                    if (w_rows_s == r_cand) begin
                        if (w_deb_inc == DEB_MAX) begin
                            w_state_nxt    = S_LATCH;
                            w_deb_nxt      = '0;
                            w_latch_en_nxt = 1'b1;
                            w_col_sel_nxt  = r_scan_col;
                            w_rows_out_nxt = r_cand;
                        end else begin
                            w_deb_nxt = w_deb_inc;
                        end
                    end else begin
                        w_deb_nxt   = '0;
                        w_col_nxt   = r_scan_col + 2'd1;
                        w_state_nxt = S_SCAN;
                    end
                end
            end
            S_LATCH: begin
                w_state_nxt      = S_WAIT_ACK;
                w_data_ready_nxt = 1'b1;
            end
            S_WAIT_ACK: begin
                if (data_ack) begin
                    w_data_ready_nxt = 1'b0;
                    w_state_nxt      = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (w_tick) begin
                    if (w_rows_s != 4'd0) begin
                        w_deb_nxt = '0;
                    end else if (w_deb_inc == DEB_MAX) begin
                        w_deb_nxt   = '0;
                        w_col_nxt   = r_scan_col + 2'd1;
                        w_state_nxt = S_SCAN;
                    end else begin
                        w_deb_nxt = w_deb_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = S_SCAN;
            end
        endcase

        w_col_drive_nxt = ~(4'b0001 << w_col_nxt);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath, synchroniser and dwell timer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell      <= '0;
            r_sync1      <= 4'b1111;
            r_sync2      <= 4'b1111;
            r_scan_col   <= 2'd0;
            r_col_drive  <= 4'b1110;
            r_cand       <= 4'd0;
            r_deb        <= '0;
            r_col_sel    <= 2'd0;
            r_rows_out   <= 4'd0;
            r_latch_en   <= 1'b0;
            r_data_ready <= 1'b0;
        end else begin
            r_dwell      <= w_tick ? '0 : r_dwell + DIV_W'(1);
            r_sync1      <= row_in;
            r_sync2      <= r_sync1;
            r_scan_col   <= w_col_nxt;
            r_col_drive  <= w_col_drive_nxt;
            r_cand       <= w_cand_nxt;
            r_deb        <= w_deb_nxt;
            r_col_sel    <= w_col_sel_nxt;
            r_rows_out   <= w_rows_out_nxt;
            r_latch_en   <= w_latch_en_nxt;
            r_data_ready <= w_data_ready_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_CNT=3.
// Edge numbers in the notes count posedges after reset is released (tick on every 4th).
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic       data_ack;
    logic [3:0] col_drive;
    logic [1:0] col_sel;
    logic [3:0] rows_out;
    logic       latch_en;
    logic       data_ready;

    int n_chk   = 0;
    int n_pass  = 0;
    int n_latch = 0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_in     (row_in),
        .col_drive  (col_drive),
        .col_sel    (col_sel),
        .rows_out   (rows_out),
        .latch_en   (latch_en),
        .data_ready (data_ready),
        .data_ack   (data_ack)
    );

    always @(negedge clk) begin
        if (latch_en === 1'b1) n_latch++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst      = 1'b1;
        row_in   = 4'hF;
        data_ack = 1'b0;
        step(2);
        rst = 1'b0;

        // Reset state
        check("rst_col_drive",  8'(col_drive),  8'h0E);
        check("rst_col_sel",    8'(col_sel),    8'h00);
        check("rst_rows_out",   8'(rows_out),   8'h00);
        check("rst_latch_en",   8'(latch_en),   8'h00);
        check("rst_data_ready", 8'(data_ready), 8'h00);

        // Idle scan: column advances every 4 clocks
        step(3);
        check("idle_e3",  8'(col_drive), 8'h0E);
        step(1);
        check("idle_e4",  8'(col_drive), 8'h0D);
        step(4);
        check("idle_e8",  8'(col_drive), 8'h0B);
        step(4);
        check("idle_e12", 8'(col_drive), 8'h07);
        step(4);
        check("idle_e16", 8'(col_drive), 8'h0E);
        step(4);
        check("idle_e20", 8'(col_drive), 8'h0D);
        check("idle_no_latch", 8'(n_latch), 8'h00);

        // Row2 pressed in column 1: ticks at E24, E28, E32 -> latch after E32
        row_in = 4'b1011;
        step(11);
        check("press_e31_latch_en", 8'(latch_en),  8'h00);
        check("press_e31_hold_col", 8'(col_drive), 8'h0D);
        step(1);
        check("press_latch_en",  8'(latch_en), 8'h01);
        check("press_col_sel",   8'(col_sel),  8'h01);
        check("press_rows_out",  8'(rows_out), 8'h04);
        step(1);
        check("press_pulse_one", 8'(latch_en),   8'h00);
        check("press_ready",     8'(data_ready), 8'h01);
        check("press_col_held",  8'(col_drive),  8'h0D);
        check("press_n_latch",   8'(n_latch),    8'h01);

        // No ack for 50 clocks
        step(50);
        check("noack_ready",   8'(data_ready), 8'h01);
        check("noack_n_latch", 8'(n_latch),    8'h01);
        check("noack_col",     8'(col_drive),  8'h0D);
        check("noack_col_sel", 8'(col_sel),    8'h01);
        data_ack = 1'b1;
        step(1);
        check("ack_ready_drop", 8'(data_ready), 8'h00);
        data_ack = 1'b0;

        // Key still held for 10 ticks after ack (E84..E124)
        step(40);
        check("held_col",      8'(col_drive), 8'h0D);
        check("held_n_latch",  8'(n_latch),   8'h01);
        check("held_rows_out", 8'(rows_out),  8'h04);
        row_in = 4'hF;
        // Release ticks E128, E132, E136
        step(11);
        check("rel_e135_col", 8'(col_drive), 8'h0D);
        step(1);
        check("rel_resume_col", 8'(col_drive), 8'h0B);
        check("rel_n_latch",    8'(n_latch),   8'h01);

        // Bounce: row0 seen on one tick (E140) then gone at E144
        row_in = 4'b1110;
        step(4);
        check("bounce_hold_col", 8'(col_drive), 8'h0B);
        row_in   = 4'hF;
        data_ack = 1'b1;
        step(4);
        check("bounce_next_col", 8'(col_drive),  8'h07);
        check("bounce_ready",    8'(data_ready), 8'h00);
        data_ack = 1'b0;
        step(4);
        check("bounce_wrap_col", 8'(col_drive), 8'h0E);
        check("bounce_n_latch",  8'(n_latch),   8'h01);
        check("bounce_col_sel",  8'(col_sel),   8'h01);

        // Second press, row3 in column 2 (driven from E156): latch after E168
        step(8);
        check("p2_col", 8'(col_drive), 8'h0B);
        row_in = 4'b0111;
        step(12);
        check("p2_latch_en", 8'(latch_en), 8'h01);
        check("p2_col_sel",  8'(col_sel),  8'h02);
        check("p2_rows_out", 8'(rows_out), 8'h08);
        step(1);
        check("p2_ready", 8'(data_ready), 8'h01);

        // Reset mid-handshake
        rst = 1'b1;
        step(1);
        check("mid_rst_ready",     8'(data_ready), 8'h00);
        check("mid_rst_col_drive", 8'(col_drive),  8'h0E);
        check("mid_rst_col_sel",   8'(col_sel),    8'h00);
        check("mid_rst_rows_out",  8'(rows_out),   8'h00);
        check("mid_rst_latch_en",  8'(latch_en),   8'h00);
        rst    = 1'b0;
        row_in = 4'hF;
        step(4);
        check("post_rst_col",     8'(col_drive), 8'h0D);
        check("post_rst_n_latch", 8'(n_latch),   8'h02);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
